// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake bundle between a producer/consumer and the
// single-clock FIFO.
//   master : drives wr_en, din, rd_en; observes data, status and error pulses
//   slave  : the FIFO side (inverse directions)
// Signals: wr_en/din (write), rd_en (read/pop), dout/dout_valid (read data),
//          full/empty/almost_full/almost_empty (status), count (occupancy),
//          overflow/underflow (one-cycle error pulses).
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO (WIDTH x DEPTH, any DEPTH>=2).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sync_fifo_param_if.slave (write/read handshake, data, status,
//          occupancy count, overflow/underflow pulses)
// Build option:
//   SYNC_FIFO_FWFT_EN defined   -> first-word-fall-through: dout shows the head
//                                  word combinationally, rd_en pops it.
//   SYNC_FIFO_FWFT_EN undefined -> standard mode, one-cycle registered read.
// Storage is not reset; only pointers, count and output registers are.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_param_if.slave      bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full, empty;
    logic             wr_acc, rd_acc;
    logic             ovf_q, udf_q;

    // Status flags come straight off the registered count.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

    // Storage: no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.din;
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Raw request against the full/empty flag: a rejected write or read
            // pulses even when the opposite side was accepted the same edge.
            ovf_q <= bus.wr_en & full;
            udf_q <= bus.rd_en & empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // last_q remembers the most recently popped word so dout holds it once
    // the FIFO drains.
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        last_q <= '0;
        else if (rd_acc) last_q <= mem[rd_ptr];
    end

    assign bus.dout       = empty ? last_q : mem[rd_ptr];
    assign bus.dout_valid = ~empty;
`else
    logic [WIDTH-1:0] dout_q;
    logic             dvld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            dvld_q <= 1'b0;
        end else begin
            dvld_q <= rd_acc;
            if (rd_acc) dout_q <= mem[rd_ptr];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dvld_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized + directed bench for sync_fifo_param.
// A queue holds the expected contents; expectations for count, flags, data
// and error pulses are derived from queue size and the acceptance rules.
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // reference state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last;
    logic             e_vld, e_ovf, e_udf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : last;
`else
        return last;
`endif
    endfunction

    function automatic logic exp_valid();
`ifdef SYNC_FIFO_FWFT_EN
        return q.size() != 0;
`else
        return e_vld;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
        chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".af"},    32'(bus.almost_full),  32'(q.size() >= AF));
        chk({tag, ".ae"},    32'(bus.almost_empty), 32'(q.size() <= AE));
        chk({tag, ".ovf"},   32'(bus.overflow),   32'(e_ovf));
        chk({tag, ".udf"},   32'(bus.underflow),  32'(e_udf));
        chk({tag, ".vld"},   32'(bus.dout_valid), 32'(exp_valid()));
        chk({tag, ".dout"},  32'(bus.dout),       32'(exp_dout()));
    endtask

    // One clock: drive, let the edge happen, advance the model, check.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [WIDTH-1:0] d);
        bit was_full, was_empty;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        e_ovf = w && was_full;
        e_udf = r && was_empty;
        e_vld = 1'b0;
        if (r && !was_empty) begin
            last  = q.pop_front();
            e_vld = 1'b1;
        end
        if (w && !was_full) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        last  = '0;
        e_vld = 1'b0;
        e_ovf = 1'b0;
        e_udf = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        model_reset();
        #3;
        check_all("rst");
        @(negedge clk);
        rst = 1'b1;

        // 1: three writes, idle, three reads
        for (int i = 1; i <= 3; i++) step("t1w", 1'b1, 1'b0, 8'(i));
        step("t1i", 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            step("t1r", 1'b0, 1'b1, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t1_data", 32'(bus.dout), 32'(i));
`endif
        end
        chk("t1_empty", 32'(bus.empty), 32'd1);

        // 2: fill, overflow, first read
        for (int i = 0; i < 16; i++) step("t2w", 1'b1, 1'b0, 8'hA0 + 8'(i));
        chk("t2_full", 32'(bus.full), 32'd1);
        step("t2ovf", 1'b1, 1'b0, 8'hEE);
        chk("t2_ovf", 32'(bus.overflow), 32'd1);
        chk("t2_cnt", 32'(bus.count), 32'd16);
        step("t2idle", 1'b0, 1'b0, 8'h00);

        // 3: full with both requests
        step("t3", 1'b1, 1'b1, 8'h55);
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        chk("t3_cnt", 32'(bus.count), 32'd15);
        chk("t3_a0", 32'(last), 32'hA0);

        // drain, 4: empty with both requests
        while (q.size() != 0) step("drain", 1'b0, 1'b1, 8'h00);
        step("t4", 1'b1, 1'b1, 8'h77);
        chk("t4_udf", 32'(bus.underflow), 32'd1);
        chk("t4_cnt", 32'(bus.count), 32'd1);
        step("t4r", 1'b0, 1'b1, 8'h00);
        chk("t4_data", 32'(bus.dout), 32'h77);

        // 5: hold count at 8 across pointer wrap
        for (int i = 0; i < 8; i++) step("t5f", 1'b1, 1'b0, 8'(i));
        for (int i = 8; i < 48; i++) begin
            step("t5", 1'b1, 1'b1, 8'(i));
            chk("t5_cnt", 32'(bus.count), 32'd8);
        end

        // randomized traffic with shifting read/write bias
        for (int ph = 0; ph < 4; ph++) begin
            int wb = (ph % 2 == 0) ? 80 : 25;
            for (int n = 0; n < 120; n++)
                step("rnd", ($urandom_range(0, 99) < wb),
                     ($urandom_range(0, 99) < 100 - wb), 8'($urandom));
        end

        // 6: asynchronous reset with 5 entries stored
        while (q.size() != 0) step("drain6", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step("t6f", 1'b1, 1'b0, 8'h60 + 8'(i));
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t6rst");
        chk("t6_dout0", 32'(bus.dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step("t6w", 1'b1, 1'b0, 8'h3C);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t6_fwft", 32'(bus.dout), 32'h3C);
`endif
        step("t6r", 1'b0, 1'b1, 8'h00);
        chk("t6_data", 32'(bus.dout), 32'h3C);
        step("t6i", 1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; successor to the fixed 8-bit x 1K buffer.
- Generalised data width and depth.
- Adds almost-full/almost-empty thresholds, an occupancy count output, overflow/underflow error pulses, a read-data-valid strobe, and correct simultaneous read/write accounting.
- Sits between producer/consumer blocks in the same clock domain, e.g. UART/SPI datapaths in the project tree.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 16: number of entries, >=2; any integer, not required to be a power of 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.
- CW, $clog2(DEPTH+1): width of the count output; derived, not overridden.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous active-low reset.
- wr_en, in, 1: write request.
- din, in, WIDTH: write data.
- rd_en, in, 1: read request.
- dout, out, WIDTH: read data.
- dout_valid, out, 1: dout holds freshly read data.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AF_LEVEL.
- almost_empty, out, 1: count <= AE_LEVEL.
- count, out, CW: current occupancy, 0..DEPTH.
- overflow, out, 1: one-cycle pulse, write rejected.
- underflow, out, 1: one-cycle pulse, read rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents immediately; first edge after release behaves as an empty FIFO.
- Acceptance, evaluated on pre-edge state:
  - wr_acc = wr_en & !full; rd_acc = rd_en & !empty.
- Write: on wr_acc, mem[wr_ptr] <= din; wr_ptr advances, wrapping from DEPTH-1 to 0.
- Read (standard mode):
  - On rd_acc, dout <= mem[rd_ptr] one cycle after the request edge; rd_ptr advances with the same wrap.
  - dout_valid=1 for exactly the cycle following each accepted read.
  - dout holds its last value otherwise; it is never driven Z.
- Count:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
  - Never exceeds DEPTH or drops below 0.
- Simultaneous events:
  - Full with wr_en & rd_en: read accepted, write rejected, overflow pulses, count goes to DEPTH-1.
  - Empty with wr_en & rd_en: write accepted, read rejected, underflow pulses, count goes to 1.
  - Partially filled with both: both accepted, count unchanged, pointers both advance.
- Errors:
  - overflow registered = wr_en & full.
  - underflow registered = rd_en & empty.
  - Each is a one-cycle pulse per offending request; state is not altered.
- Status flags: full, empty, almost_full and almost_empty are combinational from the registered count. No latency beyond count.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout presents mem[rd_ptr] combinationally whenever !empty.
  - dout_valid = !empty.
  - rd_en acts as a pop acknowledge; the next word appears in the cycle after the pop edge.
  - When empty, dout holds the last popped word.
  - All counting, flag and error rules are unchanged.
- Undefined: standard mode with registered, one-cycle read latency, as in Behaviour.

Test Plan (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2):
1. Reset then write 0x01..0x03, idle, then read 3 times:
   - dout=0x01,0x02,0x03 one cycle after each read edge, with dout_valid high on those cycles.
   - count goes 3->0; empty=1.
2. Write 16 words 0xA0..0xAF:
   - almost_full rises at count=14; full at count=16.
   - A 17th write gives overflow=1 for one cycle and count stays 16.
   - Reading back returns 0xA0 first.
3. FIFO full, assert wr_en=1, rd_en=1, din=0x55 for one cycle:
   - Read accepted, write rejected, overflow=1, count=15.
4. FIFO empty, assert wr_en=1, rd_en=1, din=0x77:
   - underflow=1, count=1; a subsequent read returns 0x77.
5. Wrap test with count held at 8:
   - Run 40 cycles of simultaneous write and read with incrementing data.
   - Read data appears in order across the pointer wrap and count stays 8 throughout.
6. With 5 entries stored, pull rst low between clock edges:
   - count=0, empty=1, dout=0, dout_valid=0 immediately.
   - After release, write 0x3C then read: returns 0x3C.
   - Under SYNC_FIFO_FWFT_EN, 0x3C appears on dout the cycle after the write, with no read latency.
